// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
// Generic inter-stage pipeline register (ID/EX, EX/MEM, MEM/WB) with a
// valid/ready handshake and a 2-entry skid buffer. The buffer keeps full
// throughput under back-pressure without any combinational path from
// out_ready to in_ready.
//
// Handshake: a beat moves across an interface on a rising clk edge where
// valid and ready are both 1. A producer holds valid and the payload stable
// until that edge. The stage never withdraws out_valid without a consume,
// flush or reset. in_ready comes straight from a flop and is computed one
// cycle ahead from the next state.
//
// Storage: MAIN drives the outputs. SKID is a hidden second entry that only
// fills when a beat is accepted while MAIN is stalled.
// Flush empties both entries without touching out_data.
// Halt: once a halt beat is accepted, input is closed. The beat drains
// normally, and its consumption sets the sticky 'halted' flag.
module pipe_stage_skid #(
    parameter int CTRL_W = 12,
    parameter int DATA_W = 128,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_halt,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic              out_halt,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Occupancy of the two-entry buffer.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [CTRL_W-1:0] main_ctrl_q;
    logic [DATA_W-1:0] main_data_q;
    logic              main_halt_q;
    logic [CTRL_W-1:0] skid_ctrl_q;
    logic [DATA_W-1:0] skid_data_q;
    logic              skid_halt_q;

    logic              in_ready_q;
    logic              in_ready_d;
    logic              halt_seen_q;
    logic              halt_seen_d;
    logic              halted_q;
    logic              halted_d;
    logic [CNT_W-1:0]  stall_cnt_q;

    logic accept;
    logic consume;
    logic load_main_in;
    logic load_main_skid;
    logic load_skid_in;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // MAIN is valid in ONE and TWO. out_valid is therefore a decode of the
    // state flop only.
    assign out_valid = (state_q != ST_EMPTY);
    assign in_ready  = in_ready_q;

    // A bubble must never assert Regwrite/Memwrite or halt downstream. The
    // payload is left ungated so that out_data holds its last value.
    assign out_ctrl  = main_ctrl_q & {CTRL_W{out_valid}};
    assign out_halt  = main_halt_q & out_valid;
    assign out_data  = main_data_q;
    assign halted    = halted_q;
    assign stall_cnt = stall_cnt_q;

    assign accept  = in_valid & in_ready_q;
    assign consume = out_valid & out_ready;

    // Next state, data-path load selects and the look-ahead in_ready.
    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid_in   = 1'b0;
        halt_seen_d    = halt_seen_q;
        halted_d       = halted_q;

        // A completed halt beat is sticky even if a flush lands on the same
        // edge: the downstream stage has already taken it.
        if (consume && main_halt_q) begin
            halted_d = 1'b1;
        end

        if (flush) begin
            // Drop everything buffered, including any beat offered this
            // cycle. An unconsumed halt is dropped too, so input reopens.
            state_d     = ST_EMPTY;
            halt_seen_d = 1'b0;
        end else begin
            if (accept && in_halt) begin
                halt_seen_d = 1'b1;
            end
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d      = ST_ONE;
                        load_main_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && consume) begin
                        load_main_in = 1'b1;
                    end else if (accept) begin
                        state_d      = ST_TWO;
                        load_skid_in = 1'b1;
                    end else if (consume) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // in_ready_q is 0 here, so no accept can arrive.
                    if (consume) begin
                        state_d        = ST_ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end

        in_ready_d = (state_d != ST_TWO) & ~halt_seen_d & ~halted_d;
    end

    // State and control flags. in_ready is low while the stage is in reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b0;
            halt_seen_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            halt_seen_q <= halt_seen_d;
            halted_q    <= halted_d;
        end
    end

    // MAIN entry: loaded from the input or promoted from SKID.
    always_ff @(posedge clk) begin
        if (!rst) begin
            main_ctrl_q <= '0;
            main_data_q <= '0;
            main_halt_q <= 1'b0;
        end else if (load_main_in) begin
            main_ctrl_q <= in_ctrl;
            main_data_q <= in_data;
            main_halt_q <= in_halt;
        end else if (load_main_skid) begin
            main_ctrl_q <= skid_ctrl_q;
            main_data_q <= skid_data_q;
            main_halt_q <= skid_halt_q;
        end
    end

    // SKID entry: catches the beat accepted while MAIN is stalled.
    always_ff @(posedge clk) begin
        if (!rst) begin
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_halt_q <= 1'b0;
        end else if (load_skid_in) begin
            skid_ctrl_q <= in_ctrl;
            skid_data_q <= in_data;
            skid_halt_q <= in_halt;
        end
    end

    // Saturating count of cycles in which a valid output waits on downstream.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else if (out_valid && !out_ready && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_q <= stall_cnt_q + CNT_ONE;
        end
    end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed EX/MEM-style pipeline register; generic inter-stage register for the CPU pipeline (ID/EX, EX/MEM, MEM/WB).
- Adds a valid/ready handshake with a 2-entry skid buffer, so the stage sustains full throughput under back-pressure.
- Adds a flush that inserts a bubble, control-field gating on bubbles, sticky halt propagation, and a stall-cycle counter.

Parameters:
- CTRL_W, 12: control-bit width (rw[4:0], jal, Memwrite, MemToReg, Regwrite, RegDst, lb, lui); forced to 0 on bubbles.
- DATA_W, 128: payload width (B, Imm, PC, ALU); never gated.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-low (0 = reset).
- in_valid  in  1  upstream beat present.
- in_ready  out  1  stage can accept; registered, equals "skid entry empty and not halted".
- in_ctrl  in  CTRL_W  upstream control bits.
- in_data  in  DATA_W  upstream payload.
- in_halt  in  1  beat is the halt instruction.
- flush  in  1  kill all buffered beats this cycle.
- out_valid  out  1  downstream beat present.
- out_ready  in  1  downstream accepts.
- out_ctrl  out  CTRL_W  control bits; all 0 whenever out_valid=0.
- out_data  out  DATA_W  payload; holds its last value when invalid.
- out_halt  out  1  halt flag of the current output beat; 0 when invalid.
- halted  out  1  sticky; set once a halt beat is consumed downstream.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0; saturating.

Behaviour:
- Reset (rst=0 at a clk edge): state EMPTY, out_valid=0, out_ctrl=0, out_data=0, out_halt=0, in_ready=0 during reset, halted=0, stall_cnt=0, skid contents=0.
- First cycle after reset release: in_ready=1.
- Storage: MAIN register drives the outputs; SKID register is a hidden second entry.
- Accept = in_valid & in_ready. Consume = out_valid & out_ready.
- States and transitions:
  - EMPTY: accept -> ONE; the beat loads MAIN; out_valid=1 next cycle.
  - ONE: accept & consume -> ONE, MAIN <= input. Accept only -> TWO, SKID <= input. Consume only -> EMPTY.
  - TWO: in_ready=0. Consume -> ONE, MAIN <= SKID. An accept in TWO is impossible by construction.
- Latency: 1 cycle input->output. Throughput: 1 beat/cycle while out_ready=1.
- Ordering: strictly FIFO; no beat is dropped or duplicated.
- in_ready is registered and equals (next state != TWO) & ~halt_seen. No combinational path from out_ready to in_ready.
- Flush (rst=1, flush=1):
  - Next state EMPTY, out_valid=0, out_ctrl=0, out_halt=0.
  - out_data unchanged; in_ready=1 next cycle unless halted.
  - Any same-cycle accept is discarded.
  - A same-cycle consume still completes downstream; the stage takes no extra action for it.
- Halt:
  - Accepting a beat with in_halt=1 sets internal halt_seen; in_ready=0 from the next cycle.
  - The halt beat drains normally. When it is consumed, halted <= 1.
  - halted stays set until reset; flush does not clear it.
  - Flush before that consume clears halt_seen, and in_ready returns to 1.
- Bubble gating: out_ctrl and out_halt are AND-ed with out_valid. A bubble therefore never asserts Regwrite or Memwrite.
- stall_cnt: increments when out_valid & ~out_ready and saturates at 2^CNT_W-1. Unaffected by flush; cleared only by reset.
- Reset mid-operation: all buffered beats are lost, with no output glitch beyond the reset values.

Test Plan:
- Reset then stream: hold rst=0 for 2 cycles, then drive 4 beats with ctrl=0x001..0x004 and data=k*0x10 while out_ready=1. Required: out_valid on cycles 1..4 after the first accept, same order, stall_cnt=0, in_ready held at 1.
- Back-pressure skid: stream beats A, B, C with out_ready=0 from A's output cycle. Required: A held at the output, B in skid, in_ready=0, C held upstream. Raise out_ready: A, B, C emerge on consecutive cycles. stall_cnt equals the number of stalled cycles, e.g. 3 stalled cycles -> 3.
- Flush with two entries: in state TWO, assert flush for 1 cycle. Required: next cycle out_valid=0, out_ctrl=0x000, out_halt=0, in_ready=1, out_data still A's value; the next accepted beat appears after 1 cycle.
- Halt: send beat with in_halt=1 then beat X. Required: X is not accepted (in_ready=0 after the halt accept). After the halt beat is consumed, halted=1, and it stays 1 through a later flush. Reset clears it.
- Flush races halt: accept the halt beat, hold out_ready=0, then flush. Required: halted=0, in_ready=1, and a new beat is accepted.
- Counter saturation: with CNT_W=4, stall for 20 cycles. Required: stall_cnt=15 and held there.
